ram_ar_aw_ctrl: RTL and testbench
=================================

Name: ram_ar_aw_ctrl

Overview:
- Synchronous initiator that drives one port of the team's asynchronous-read/asynchronous-write RAM through its cs/we/oe/address/data pins.
- Converts a clocked valid/ready request stream (read or write) into pin sequences with programmable setup, pulse and hold cycles.
- Returns read data on a valid/ready response channel.
- Sits between bus-side logic and the async RAM macro, so that no async pin is ever driven from combinational logic.

Parameters:
- DATA_WIDTH, 8, data bus width.
- ADDR_WIDTH, 8, address width.
- SETUP_CYC, 1, cycles with cs/address/data stable before the we pulse (min 1).
- PULSE_CYC, 2, cycles with we asserted (min 1).
- HOLD_CYC, 1, cycles with cs/address/data held after we drops (min 1).
- RD_WAIT_CYC, 2, cycles with cs/oe asserted before read data is sampled (min 1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  downstream accepts the response.
- rsp_rdata  out  DATA_WIDTH  captured read data.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_cs  out  1  to RAM chip select.
- ram_we  out  1  to RAM write enable.
- ram_oe  out  1  to RAM output enable.
- ram_wdata  out  DATA_WIDTH  to RAM write-data input.
- ram_rdata  in  DATA_WIDTH  from RAM read-data output.

Behaviour:
- Reset (async, rst_n=0), applied immediately:
  - state=IDLE.
  - ram_cs, ram_we, ram_oe, rsp_valid = 0.
  - ram_address, ram_wdata, rsp_rdata = 0.
  - Phase counter = 0.
  - req_ready = (state==IDLE), so it reads 1 once out of reset. Upstream must not issue requests during reset.
- Registered outputs: all ram_* pins and rsp_* outputs are flops. req_ready is combinational from state.
- Accept: a handshake is req_valid && req_ready at a rising edge. Address, data and we are latched at that edge. req_valid while busy is ignored; nothing is queued.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, RD_RESP.
- Phase counter: loaded with N-1 on entry to each timed state; the state exits when the counter is 0.
- Write, accepted at edge 0:
  - Cycles 1..S: WR_SETUP, cs=1, we=0, oe=0, address and wdata driven.
  - Next P cycles: WR_PULSE, we=1.
  - Next H cycles: WR_HOLD, we=0, cs=1.
  - Then IDLE, with cs=0 and req_ready=1.
  - Occupancy is S+P+H cycles. Defaults: ready again at cycle 5.
  - ram_address and ram_wdata are constant from the first SETUP cycle through the last HOLD cycle.
  - Writes produce no response.
- Read, accepted at edge 0:
  - Cycles 1..R: RD_ACCESS, cs=1, oe=1, we=0.
  - ram_rdata is captured into rsp_rdata at the edge ending cycle R.
  - Next cycle: RD_RESP, cs=0, oe=0, rsp_valid=1.
  - rsp_valid and rsp_rdata hold stable until rsp_ready. On the handshake edge: rsp_valid=0, state goes to IDLE.
  - Minimum read turnaround is R+2 cycles, including 1 IDLE cycle.
- Invariants:
  - ram_we and ram_oe are never both 1.
  - ram_we=1 implies ram_cs=1.
  - There is always at least 1 cycle with cs=0 between operations.
- Idle pins: ram_address and ram_wdata keep their last values; cs, we and oe are 0.
- Reset mid-operation: the pins drop to 0 asynchronously and the in-flight request is discarded. A partial write may leave the target word undefined. A pending response is lost.
- Parameter widths: counter width is $clog2 of the maximum timing parameter plus 1. All timing parameters must be ≥ 1; an elaboration check enforces this.

Decomposition:
- Package ram_ctrl_pkg:
  - state enum.
  - Default timing constants.
  - Counter-width function.
- One sub-module, ram_phase_timer: a loadable down-counter with a zero flag, reused for every timed state.

Test Plan:
- Write 0xA5 to address 0x3C (defaults) -> cs=1 on cycles 1-4, we=1 on cycles 2-3 only, address=0x3C and wdata=0xA5 constant cycles 1-4, req_ready=1 at cycle 5. The RAM model holds 0xA5 at 0x3C.
- Read address 0x3C after that write -> cs=oe=1 on cycles 1-2, rsp_valid=1 at cycle 3 with rsp_rdata=0xA5.
- Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5, req_ready=0 throughout. The request drops 1 cycle after rsp_ready=1.
- req_valid held high with alternating write/read to 0x00..0x0F -> each op is accepted only in IDLE, none are lost or duplicated, read-back matches the written data.
- rst_n=0 during WR_PULSE -> cs, we and oe are 0 in the same cycle without waiting for a clock edge; after release req_ready=1 and rsp_valid=0.
- SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2, RD_WAIT_CYC=4 -> write occupies 6 cycles, read response appears at cycle 5, invariants hold (scoreboard assertions).

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the async-RAM initiator: FSM state encoding,
// default pin timings and the phase counter width calculation.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ACCESS,
    RD_RESP
  } state_t;

  localparam int DEF_SETUP_CYC   = 1;
  localparam int DEF_PULSE_CYC   = 2;
  localparam int DEF_HOLD_CYC    = 1;
  localparam int DEF_RD_WAIT_CYC = 2;

  // Wide enough to hold the largest (N-1) load value with one bit to spare.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ram_phase_timer.sv
// Loadable down-counter with a zero flag; times every setup/pulse/hold/wait phase.
module ram_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ram_ar_aw_ctrl.sv
// Clocked valid/ready front end for an async-read/async-write RAM port.
// Every RAM pin and response output is driven straight from a flop.
module ram_ar_aw_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int PULSE_CYC   = DEF_PULSE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int RD_WAIT_CYC = DEF_RD_WAIT_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC, RD_WAIT_CYC);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RDW_LD   = CW'(RD_WAIT_CYC - 1);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || RD_WAIT_CYC < 1) begin : g_bad_timing
    $error("ram_ar_aw_ctrl: all timing parameters must be >= 1");
  end

  state_t          state;
  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic            tmr_zero;

  assign req_ready = (state == IDLE);

  // The counter is reloaded on the same edge that enters the next timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          tmr_load = 1'b1;
          tmr_val  = req_we ? SETUP_LD : RDW_LD;
        end
      end
      WR_SETUP: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      WR_PULSE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      default: ;
    endcase
  end

  ram_phase_timer #(
    .WIDTH(CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_address <= '0;
      ram_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ram_address <= req_addr;
            ram_wdata   <= req_wdata;
            ram_cs      <= 1'b1;
            if (req_we) begin
              state <= WR_SETUP;
            end else begin
              ram_oe <= 1'b1;
              state  <= RD_ACCESS;
            end
          end
        end
        WR_SETUP: begin
          if (tmr_zero) begin
            ram_we <= 1'b1;
            state  <= WR_PULSE;
          end
        end
        WR_PULSE: begin
          if (tmr_zero) begin
            ram_we <= 1'b0;
            state  <= WR_HOLD;
          end
        end
        WR_HOLD: begin
          if (tmr_zero) begin
            ram_cs <= 1'b0;
            state  <= IDLE;
          end
        end
        RD_ACCESS: begin
          if (tmr_zero) begin
            rsp_rdata <= ram_rdata;
            rsp_valid <= 1'b1;
            ram_cs    <= 1'b0;
            ram_oe    <= 1'b0;
            state     <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ar_aw_ctrl.sv
// Bench for ram_ar_aw_ctrl: default-timing instance plus a slow-timing instance,
// each talking to a behavioural async RAM.
module tb_ram_ar_aw_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [7:0] req_addr, req_wdata, rsp_rdata;
  logic [7:0] ram_address, ram_wdata, ram_rdata;
  logic       ram_cs, ram_we, ram_oe;

  logic       req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b;
  logic [7:0] req_addr_b, req_wdata_b, rsp_rdata_b;
  logic [7:0] ram_address_b, ram_wdata_b, ram_rdata_b;
  logic       ram_cs_b, ram_we_b, ram_oe_b;

  ram_ar_aw_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_address(ram_address), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_ar_aw_ctrl #(
    .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2), .RD_WAIT_CYC(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
    .ram_address(ram_address_b), .ram_cs(ram_cs_b), .ram_we(ram_we_b), .ram_oe(ram_oe_b),
    .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
  );

  // Behavioural async RAMs: written while cs&we, read data only while cs&oe.
  logic [7:0] mem   [256];
  logic [7:0] mem_b [256];
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_address] <= ram_wdata;
  always @(posedge clk) if (ram_cs_b && ram_we_b) mem_b[ram_address_b] <= ram_wdata_b;
  assign ram_rdata   = (ram_cs && ram_oe) ? mem[ram_address] : 8'h00;
  assign ram_rdata_b = (ram_cs_b && ram_oe_b) ? mem_b[ram_address_b] : 8'h00;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rsp_cnt = 0;
  logic [7:0] sb [$];
  logic [7:0] ref_mem [256];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response scoreboard: a handshake seen at this negedge completes at the next posedge.
  logic [7:0] exp_rsp;
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        exp_rsp = sb.pop_front();
        check("rsp_rdata", rsp_rdata, exp_rsp);
        $display("rsp rdata=%h exp=%h", rsp_rdata, exp_rsp);
      end
    end
  end

  // Pin invariants for both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((ram_we && ram_oe) || (ram_we_b && ram_oe_b)) begin
        err_cnt++;
        $display("FAIL inv_we_oe: we and oe both high (t=%0t)", $time);
      end
      if ((ram_we && !ram_cs) || (ram_we_b && !ram_cs_b)) begin
        err_cnt++;
        $display("FAIL inv_we_cs: we high without cs (t=%0t)", $time);
      end
      if ((req_ready && ram_cs) || (req_ready_b && ram_cs_b)) begin
        err_cnt++;
        $display("FAIL inv_idle_cs: cs high while idle (t=%0t)", $time);
      end
    end
  end

  // Waits (bounded) for req_ready, then performs one handshake; returns at edge 0 + 1.
  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("issue_ready", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    if (we) ref_mem[a] = d;
    else    sb.push_back(ref_mem[a]);
    $display("txn we=%0d addr=%h wdata=%h", we, a, d);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc, t;
    logic hs;

    for (int i = 0; i < 16; i++) begin
      vecs[2*i]   = '{1'b1, 8'(i), 8'(i * 37 + 11), 8'h00};
      vecs[2*i+1] = '{1'b0, 8'(i), 8'h00, 8'(i * 37 + 11)};
    end

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 1'b1;

    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_cs", ram_cs, 0);
    check("rst_we", ram_we, 0);
    check("rst_oe", ram_oe, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_address", ram_address, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Slow-timing instance: write occupies 6 cycles, read response at cycle 5.
    @(negedge clk);
    check("b_ready", req_ready_b, 1);
    req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 8'h11; req_wdata_b = 8'h5A;
    $display("txn(b) we=1 addr=11 wdata=5a");
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("b_wr_cs_c%0d", k), ram_cs_b, k <= 6);
      check($sformatf("b_wr_we_c%0d", k), ram_we_b, k == 4);
      check($sformatf("b_wr_ready_c%0d", k), req_ready_b, k == 7);
    end
    req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 8'h11;
    $display("txn(b) we=0 addr=11");
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("b_rd_oe_c%0d", k), ram_cs_b && ram_oe_b, k <= 4);
      check($sformatf("b_rd_valid_c%0d", k), rsp_valid_b, k == 5);
      if (k == 5) check("b_rd_data", rsp_rdata_b, 8'h5A);
    end

    // Default-timing write: cs 1-4, we 2-3, ready at 5.
    issue(1'b1, 8'h3C, 8'hA5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("wr_cs_c%0d", k), ram_cs, k <= 4);
      check($sformatf("wr_we_c%0d", k), ram_we, k == 2 || k == 3);
      check($sformatf("wr_ready_c%0d", k), req_ready, k == 5);
      if (k <= 4) begin
        check($sformatf("wr_addr_c%0d", k), ram_address, 8'h3C);
        check($sformatf("wr_data_c%0d", k), ram_wdata, 8'hA5);
      end
    end
    check("ram_holds_a5", mem[8'h3C], 8'hA5);

    // Read back with the response stalled for five cycles.
    issue(1'b0, 8'h3C, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        check($sformatf("rd_cs_c%0d", k), ram_cs, 1);
        check($sformatf("rd_oe_c%0d", k), ram_oe, 1);
        check($sformatf("rd_valid_c%0d", k), rsp_valid, 0);
      end else begin
        check($sformatf("stall_valid_c%0d", k), rsp_valid, 1);
        check($sformatf("stall_data_c%0d", k), rsp_rdata, 8'hA5);
        check($sformatf("stall_cs_c%0d", k), ram_cs || ram_oe, 0);
      end
      check($sformatf("rd_ready_c%0d", k), req_ready, 0);
      if (k == 6) begin
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("rsp_drop_valid", rsp_valid, 0);
    check("rsp_drop_ready", req_ready, 1);

    // req_valid held high, alternating write/read over addresses 0x00..0x0F.
    @(posedge clk);
    #1;
    idx = 0;
    cyc = 0;
    req_valid = 1'b1;
    req_we = vecs[0].we; req_addr = vecs[0].addr; req_wdata = vecs[0].wdata;
    while (idx < 32 && cyc < 2000) begin
      @(negedge clk);
      hs = req_ready;
      if (hs) begin
        if (!vecs[idx].we) sb.push_back(vecs[idx].exp);
        else ref_mem[vecs[idx].addr] = vecs[idx].wdata;
        $display("txn we=%0d addr=%h wdata=%h", vecs[idx].we, vecs[idx].addr, vecs[idx].wdata);
      end
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx < 32) begin
          req_we = vecs[idx].we; req_addr = vecs[idx].addr; req_wdata = vecs[idx].wdata;
        end
      end
      cyc++;
    end
    req_valid = 1'b0;
    check("stream_accepts", idx, 32);
    t = 0;
    while ((sb.size() != 0 || !req_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("stream_drained", sb.size(), 0);
    check("rsp_count", rsp_cnt, 17);

    // Reset asserted mid write pulse: pins drop without a clock edge.
    issue(1'b1, 8'h80, 8'h33);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_we", ram_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cs", ram_cs, 0);
    check("async_rst_we", ram_we, 0);
    check("async_rst_oe", ram_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_valid", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
